fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined core, sitting beside the ID/EX boundary. The block keeps its own shadow of the destination registers for every in-flight instruction from EX to the last write-back stage. From that shadow it drives the EX operand-mux selects for NUM_SRC source operands across a configurable number of stages. It also detects load-use hazards in ID, inserts exactly one bubble per hazard, holds state under memory freeze and flush, and keeps saturating performance counters.

---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_hazard_unit_if.sv | 32 +++
 rtl/fwd_match.sv | 37 +++
 rtl/fwd_hazard_unit.sv | 117 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: FSM states and
// the shadow-pipeline entry that mirrors one in-flight instruction.
package fwd_pkg;

    localparam int unsigned RD_MAX_W    = 8;
    localparam int unsigned SEL_REGFILE = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2
    } fsm_state_t;

    // rd is stored zero-extended to RD_MAX_W so the struct is parameter-free
    typedef struct packed {
        logic                valid;
        logic                wb;
        logic                load;
        logic [RD_MAX_W-1:0] rd;
    } shadow_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-select response bundle between the pipeline and the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SEL_W = $clog2(DEPTH);

    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_src_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_wb_i;
    logic                      id_load_i;
    logic                      mem_busy_i;
    logic                      flush_i;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic                      stall_o;
    logic [CNT_W-1:0]          fwd_cnt_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output id_valid_i, id_src_i, id_rd_i, id_wb_i, id_load_i, mem_busy_i, flush_i,
        input  fwd_sel_o, stall_o, fwd_cnt_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_src_i, id_rd_i, id_wb_i, id_load_i, mem_busy_i, flush_i,
        output fwd_sel_o, stall_o, fwd_cnt_o, stall_cnt_o
    );

endinterface

// File: rtl/fwd_match.sv
// Priority encoder for one EX operand: returns the youngest shadow entry
// (smallest index >= 1) that will write the operand's register.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  shadow_entry_t     entries [DEPTH],
    input  logic [REG_AW-1:0] src,
    output logic [SEL_W-1:0]  sel_c
);

    logic unused_fields;

    // Scan oldest to youngest so the youngest match is the last assignment
    always_comb begin
        sel_c = SEL_W'(SEL_REGFILE);
        if (entries[0].valid) begin
            for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
                if (entries[j].valid && entries[j].wb && (entries[j].rd != '0) &&
                    (entries[j].rd == RD_MAX_W'(src))) begin
                    sel_c = SEL_W'(j);
                end
            end
        end
    end

    always_comb begin
        unused_fields = entries[0].wb ^ (^entries[0].rd);
        for (int j = 0; j < int'(DEPTH); j++) begin
            unused_fields = unused_fields ^ entries[j].load;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator; keeps a shadow of in-flight
// destinations from EX to the last write-back stage plus saturating counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fwd_hazard_unit_if.slave  bus
);

    localparam int unsigned SEL_W = $clog2(DEPTH);

    shadow_entry_t             ent_q [DEPTH];
    logic [NUM_SRC*REG_AW-1:0] ex_src_q;
    fsm_state_t                state_q, state_d, saved_q, saved_d, eff_state;
    logic [CNT_W-1:0]          fwd_cnt_q, stall_cnt_q;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_c;
    shadow_entry_t             id_entry;
    logic                      advance, src_hit, hazard_c, stall_c, take_id, any_fwd;

    assign advance  = !bus.mem_busy_i;
    assign take_id  = bus.id_valid_i && !stall_c && !bus.flush_i;
    assign any_fwd  = |fwd_sel_c;
    assign id_entry = '{valid: 1'b1, wb: bus.id_wb_i, load: bus.id_load_i,
                        rd: RD_MAX_W'(bus.id_rd_i)};

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (RD_MAX_W'(bus.id_src_i[k*REG_AW +: REG_AW]) == ent_q[0].rd) begin
                src_hit = 1'b1;
            end
        end
        hazard_c = bus.id_valid_i && ent_q[0].valid && ent_q[0].wb && ent_q[0].load &&
                   (ent_q[0].rd != '0) && src_hit && advance && !bus.flush_i;
    end

    // FREEZE acts as the saved state once busy drops, so no hazard cycle is lost on release
    always_comb begin
        eff_state = (state_q == FREEZE) ? saved_q : state_q;
        state_d   = eff_state;
        saved_d   = saved_q;
        stall_c   = 1'b0;
        if (bus.mem_busy_i) begin
            state_d = FREEZE;
            if (state_q != FREEZE) begin
                saved_d = state_q;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    stall_c = hazard_c;
                    if (hazard_c) begin
                        state_d = BUBBLE;
                    end
                end
                BUBBLE:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    for (genvar k = 0; k < int'(NUM_SRC); k++) begin : g_match
        fwd_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .entries (ent_q),
            .src     (ex_src_q[k*REG_AW +: REG_AW]),
            .sel_c   (fwd_sel_c[k*SEL_W +: SEL_W])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                ent_q[j] <= '0;
            end
            ex_src_q    <= '0;
            state_q     <= RUN;
            saved_q     <= RUN;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            if (advance) begin
                ent_q[0] <= take_id ? id_entry : '0;
                for (int j = 1; j < int'(DEPTH); j++) begin
                    ent_q[j] <= ent_q[j-1];
                end
                if (take_id) begin
                    ex_src_q <= bus.id_src_i;
                end
                if (stall_c && (stall_cnt_q != '1)) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                if (any_fwd && (fwd_cnt_q != '1)) begin
                    fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.fwd_sel_o   = fwd_sel_c;
    assign bus.stall_o     = stall_c;
    assign bus.fwd_cnt_o   = fwd_cnt_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SEL_W   = $clog2(DEPTH);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // In-flight instructions, index 0 = EX, higher = older
    bit m_v   [DEPTH];
    bit m_wb  [DEPTH];
    bit m_ld  [DEPTH];
    int m_rd  [DEPTH];
    int m_s0  [DEPTH];
    int m_s1  [DEPTH];
    int m_fwd   = 0;
    int m_stall = 0;

    int last_stall, last_sel0, last_sel1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int producer_of(input int src);
        if (!m_v[0]) return 0;
        for (int j = 1; j < int'(DEPTH); j++) begin
            if (m_v[j] && m_wb[j] && m_rd[j] != 0 && m_rd[j] == src) return j;
        end
        return 0;
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < int'(DEPTH); j++) begin
            m_v[j] = 0; m_wb[j] = 0; m_ld[j] = 0; m_rd[j] = 0; m_s0[j] = 0; m_s1[j] = 0;
        end
        m_fwd = 0;
        m_stall = 0;
    endfunction

    // One clock: drive ID, check outputs mid-cycle, clock, advance the model
    task automatic cyc(input bit v, input int rd, input int s0, input int s1, input bit wb,
                       input bit ld, input bit busy, input bit fl, input bit rs);
        int e0, e1;
        bit e_stall;
        bus.id_valid_i = v;
        bus.id_rd_i    = REG_AW'(rd);
        bus.id_src_i   = {REG_AW'(s1), REG_AW'(s0)};
        bus.id_wb_i    = wb;
        bus.id_load_i  = ld;
        bus.mem_busy_i = busy;
        bus.flush_i    = fl;
        rst            = !rs;
        #4;
        e0 = producer_of(m_s0[0]);
        e1 = producer_of(m_s1[0]);
        e_stall = v && m_v[0] && m_wb[0] && m_ld[0] && m_rd[0] != 0 &&
                  (s0 == m_rd[0] || s1 == m_rd[0]) && !busy && !fl;
        check("fwd_sel0", 32'(bus.fwd_sel_o[0 +: SEL_W]), 32'(e0));
        check("fwd_sel1", 32'(bus.fwd_sel_o[SEL_W +: SEL_W]), 32'(e1));
        check("stall", 32'(bus.stall_o), 32'(e_stall));
        check("fwd_cnt", 32'(bus.fwd_cnt_o), 32'(m_fwd));
        check("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_stall));
        last_stall = int'(bus.stall_o);
        last_sel0  = int'(bus.fwd_sel_o[0 +: SEL_W]);
        last_sel1  = int'(bus.fwd_sel_o[SEL_W +: SEL_W]);
        @(posedge clk);
        if (rs) begin
            model_clear();
        end else if (!busy) begin
            if (e_stall && m_stall < CNT_MAX) m_stall++;
            if ((e0 != 0 || e1 != 0) && m_fwd < CNT_MAX) m_fwd++;
            for (int j = int'(DEPTH) - 1; j >= 1; j--) begin
                m_v[j] = m_v[j-1]; m_wb[j] = m_wb[j-1]; m_ld[j] = m_ld[j-1];
                m_rd[j] = m_rd[j-1]; m_s0[j] = m_s0[j-1]; m_s1[j] = m_s1[j-1];
            end
            m_v[0] = v && !e_stall && !fl;
            m_wb[0] = wb; m_ld[0] = ld; m_rd[0] = rd; m_s0[0] = s0; m_s1[0] = s1;
        end
        #1;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.id_valid_i = 0; bus.id_src_i = '0; bus.id_rd_i = '0; bus.id_wb_i = 0;
        bus.id_load_i = 0; bus.mem_busy_i = 0; bus.flush_i = 0;
        rst = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 32'(bus.fwd_sel_o), 32'(0));
        check("rst_cnts", 32'({bus.fwd_cnt_o, bus.stall_cnt_o}), 32'(0));

        // add r3; sub r5,r3,r3
        cyc(1, 3, 1, 2, 1, 0, 0, 0, 0);
        cyc(1, 5, 3, 3, 1, 0, 0, 0, 0);
        nop();
        check("b2b_sel0", 32'(last_sel0), 32'(1));
        check("b2b_sel1", 32'(last_sel1), 32'(1));
        check("b2b_fwd_cnt", 32'(bus.fwd_cnt_o), 32'(1));

        // add r3; nop; add r6,r3,r0
        do_reset();
        cyc(1, 3, 1, 2, 1, 0, 0, 0, 0);
        nop();
        cyc(1, 6, 3, 0, 1, 0, 0, 0, 0);
        nop();
        check("gap_sel0", 32'(last_sel0), 32'(2));
        check("gap_sel1", 32'(last_sel1), 32'(0));

        // lw r4; add r7,r4,r1
        do_reset();
        cyc(1, 4, 1, 2, 1, 1, 0, 0, 0);
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("lu_stall", 32'(last_stall), 32'(1));
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("lu_issue", 32'(last_stall), 32'(0));
        nop();
        check("lu_sel0", 32'(last_sel0), 32'(2));
        check("lu_stall_cnt", 32'(bus.stall_cnt_o), 32'(1));

        // youngest writer wins; r0 never forwards
        do_reset();
        cyc(1, 2, 1, 1, 1, 0, 0, 0, 0);
        cyc(1, 2, 1, 1, 1, 0, 0, 0, 0);
        cyc(1, 9, 2, 2, 1, 0, 0, 0, 0);
        nop();
        check("young_sel0", 32'(last_sel0), 32'(1));
        check("young_sel1", 32'(last_sel1), 32'(1));
        do_reset();
        cyc(1, 0, 1, 1, 1, 0, 0, 0, 0);
        cyc(1, 10, 0, 0, 1, 0, 0, 0, 0);
        nop();
        check("r0_sel0", 32'(last_sel0), 32'(0));

        // load-use held under 3 busy cycles
        do_reset();
        cyc(1, 4, 1, 2, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 7, 4, 1, 1, 0, 1, 0, 0);
            check("busy_stall", 32'(last_stall), 32'(0));
            check("busy_stall_cnt", 32'(bus.stall_cnt_o), 32'(0));
        end
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("rel_stall", 32'(last_stall), 32'(1));
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("rel_issue", 32'(last_stall), 32'(0));
        nop();
        check("rel_sel0", 32'(last_sel0), 32'(2));
        check("rel_stall_cnt", 32'(bus.stall_cnt_o), 32'(1));

        // reset in the bubble cycle with a full pipe
        do_reset();
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 4, 1, 2, 1, 1, 0, 0, 0);
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("bub_stall", 32'(last_stall), 32'(1));
        cyc(1, 7, 4, 1, 1, 0, 1, 1, 1);
        check("bub_rst_sel", 32'(bus.fwd_sel_o), 32'(0));
        check("bub_rst_cnt", 32'(bus.stall_cnt_o), 32'(0));
        cyc(1, 7, 4, 1, 1, 0, 0, 0, 0);
        check("bub_rst_stall", 32'(last_stall), 32'(0));

        // flush beats a hazard
        do_reset();
        cyc(1, 4, 1, 2, 1, 1, 0, 0, 0);
        cyc(1, 7, 4, 1, 1, 0, 0, 1, 0);
        check("fl_stall", 32'(last_stall), 32'(0));
        nop();
        check("fl_stall_cnt", 32'(bus.stall_cnt_o), 32'(0));
        check("fl_bubble_sel", 32'(last_sel0), 32'(0));

        // random traffic on a small register window to provoke hazards and saturation
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(9, 0) != 0, int'($urandom_range(7, 0)),
                int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                $urandom_range(4, 0) != 0, $urandom_range(2, 0) == 0,
                $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0,
                $urandom_range(199, 0) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
